// File: rtl/cpu_pkg.sv
// Shared multicycle CPU definitions: memory FSM encoding, word size, control-word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Memory responder FSM encoding, shared with checkers that decode the state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_e;

    localparam int WORD_BYTES = 4;

    // ControlUnit control word, MSB first; checks rely on this bit order.
    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable wait-state down-counter; flags the cycle whose decrement reaches zero.
// Latency: load/decrement take effect on the next clock edge.
// Backpressure: none; the caller decides when to load and decrement.
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current decrement is the last wait cycle.
    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/multicycle_memory_responder.sv
// Unified I/D memory for the multicycle CPU with programmable wait states and error flagging.
// Latency: request accepted at edge N -> mem_ready/mem_error pulse after edge N+WAIT_STATES.
// Backpressure: requester holds its request until mem_ready; new requests only accepted in IDLE.
module multicycle_memory_responder
    import cpu_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_ready,
    output logic                  mem_error,
    output logic                  busy
);

    localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]            WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_ready_q;
    logic                  mem_error_q;

    logic                  accept;
    logic                  wait_expire;
    logic                  enter_resp;
    logic                  req_err_d;
    logic [ADDR_WIDTH-3:0] word_idx_d;
    logic [IDX_W-1:0]      rd_idx_d;
    logic [IDX_W-1:0]      wr_idx_q;

    assign accept = (state_q == S_IDLE) && (mem_read || mem_write);

    mem_wait_counter #(.W(4)) u_wait_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (WS),
        .dec_i      (state_q == S_WAIT),
        .expire_o   (wait_expire)
    );

    // Next state and request capture; only IDLE looks at the live request inputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_expire) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request legality is judged on the captured request (addr_d covers the zero-wait case).
    always_comb begin
        word_idx_d = addr_d[ADDR_WIDTH-1:2];
        rd_idx_d   = word_idx_d[IDX_W-1:0];
        req_err_d  = (addr_d[1:0] != 2'b00) || (word_idx_d >= DEPTH_W) || (rd_d && wr_d);
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    end

    assign wr_idx_q = addr_q[IDX_W+1:2];

    // FSM, captured request and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            mem_ready_q <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            mem_ready_q <= enter_resp;
            mem_error_q <= enter_resp && req_err_d;
            if (enter_resp && rd_d && !req_err_d) begin
                rdata_q <= mem[rd_idx_d];
            end
        end
    end

    // Single write commit on the edge leaving RESP; a reset on that edge drops it.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == S_RESP) && wr_q && !mem_error_q) begin
            mem[wr_idx_q] <= wdata_q;
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_error = mem_error_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_multicycle_memory_responder.sv
// Randomized scoreboard bench for multicycle_memory_responder (WAIT_STATES=2 and 0 instances).
// Latency: expected response latency WAIT_STATES+1 negedges after driving the request.
// Backpressure: driver holds each request until mem_ready, then drops it.
module tb_multicycle_memory_responder;

    localparam int DEPTH  = 256;
    localparam int WS     = 2;
    localparam int DEPTH0 = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        mem_ready, mem_error, busy;

    logic        mem_read0, mem_write0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        mem_ready0, mem_error0, busy0;

    always #5 clock = ~clock;

    multicycle_memory_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS), .INIT_FILE("")
    ) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready),
        .mem_error(mem_error), .busy(busy)
    );

    multicycle_memory_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH0), .WAIT_STATES(0), .INIT_FILE("")
    ) dut0 (
        .clock(clock), .reset(reset), .mem_read(mem_read0), .mem_write(mem_write0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .mem_ready(mem_ready0),
        .mem_error(mem_error0), .busy(busy0)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response from the main DUT is matched against the oldest expectation.
    always @(negedge clock) begin
        resp_t e;
        if (!reset && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("resp_error", 32'(mem_error), 32'(e.err));
                check("resp_rdata", rdata, e.rdata);
            end
        end else if (!reset && mem_error) begin
            check("error_without_ready", 32'(mem_error), 32'd0);
        end
    end

    // Reference model: legality and memory effects, then the expected response is queued.
    task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d);
        resp_t e;
        logic  err;
        err = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH) || (rd && wr);
        if (!err && rd) model_rdata = model_mem[a >> 2];
        if (!err && wr) model_mem[a >> 2] = d;
        e.rdata = model_rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
        int n;
        model_access(rd, wr, a, d);
        @(negedge clock);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                check("busy_during_access", 32'(busy), 32'd1);
                // Latched request must be used: scramble the bus while waiting.
                addr  = $urandom;
                wdata = $urandom;
            end
        end while (!mem_ready && n < 20);
        if (!mem_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, required %0d", n, WS + 1);
        end else begin
            check("latency", 32'(n), 32'(WS + 1));
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = $urandom;
        wdata     = $urandom;
        @(negedge clock);
        check("ready_one_cycle", 32'(mem_ready), 32'd0);
        check("idle_after_resp", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] old4;
        int          pulses;
        int          r;
        logic        rd, wr;
        logic [31:0] a;

        reset = 1'b1;
        mem_read = 1'b0;  mem_write = 1'b0;  addr = '0;  wdata = '0;
        mem_read0 = 1'b0; mem_write0 = 1'b0; addr0 = '0; wdata0 = '0;
        model_rdata = '0;
        repeat (3) @(negedge clock);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_error", 32'(mem_error), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        reset = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) do_access(1'b0, 1'b1, 32'(i * 4), $urandom);

        do_access(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h4, 32'h0);
        do_access(1'b0, 1'b1, 32'h8, 32'h12345678);
        do_access(1'b1, 1'b0, 32'h8, 32'h0);
        do_access(1'b1, 1'b0, 32'h6, 32'h0);
        do_access(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
        do_access(1'b0, 1'b1, 32'(4 * DEPTH), 32'hA5A5A5A5);
        do_access(1'b1, 1'b1, 32'h8, 32'hFFFF0000);
        do_access(1'b1, 1'b0, 32'h8, 32'h0);

        // Reset during the WAIT of a write to 0x10: the write must be dropped.
        old4 = model_mem[4];
        @(negedge clock);
        mem_write = 1'b1; addr = 32'h10; wdata = ~old4;
        @(negedge clock);
        check("busy_before_abort", 32'(busy), 32'd1);
        mem_write = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_rdata", rdata, 32'd0);
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_error", 32'(mem_error), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        reset = 1'b0;
        model_rdata = '0;
        do_access(1'b1, 1'b0, 32'h10, 32'h0);

        // Random traffic mixing legal and illegal requests.
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 9);
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if (r == 6) a = a | 32'($urandom_range(1, 3));
            if (r == 7) a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
            if (r >= 8) begin rd = 1'b1; wr = 1'b1; end
            do_access(rd, wr, a, $urandom);
        end

        // Zero wait states with a held read: one response every second cycle.
        pulses = 0;
        @(negedge clock);
        mem_read0 = 1'b1; addr0 = 32'h0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clock);
            check("ws0_ready_pattern", 32'(mem_ready0), 32'(j % 2));
            if (mem_ready0) begin
                pulses++;
                check("ws0_error", 32'(mem_error0), 32'd0);
            end
        end
        mem_read0 = 1'b0;
        @(negedge clock);
        check("ws0_no_extra_ready", 32'(mem_ready0), 32'd0);
        check("ws0_pulse_count", 32'(pulses), 32'd3);

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
